// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32IM hazard controller: forward-select codes and divider FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side bundle of the hazard controller: register ids and strobes in, forward/stall/flush controls out.
interface hazard_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic              RegWriteM;
  logic [REG_AW-1:0] RD_M;
  logic              RegWriteW;
  logic [REG_AW-1:0] RD_W;
  logic [REG_AW-1:0] Rs1_D;
  logic [REG_AW-1:0] Rs2_D;
  logic [REG_AW-1:0] Rs1_E;
  logic [REG_AW-1:0] Rs2_E;
  logic [REG_AW-1:0] RD_E;
  logic              MemReadE;
  logic              DivStartE;
  logic              PCSrcE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              DivBusy;
  logic              DivDone;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output RegWriteM, RD_M, RegWriteW, RD_W, Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E,
           MemReadE, DivStartE, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
           DivBusy, DivDone, StallCount
  );

  modport slave (
    input  RegWriteM, RD_M, RegWriteW, RD_W, Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E,
           MemReadE, DivStartE, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
           DivBusy, DivDone, StallCount
  );
endinterface

// File: rtl/hazard_div_interlock_fsm.sv
// Divider interlock: holds EX for DIV_CYCLES cycles from the start cycle, then pulses DivDone for one cycle.
// DONE ignores DivStartE so the divide still sitting in EX cannot retrigger itself.
module div_interlock_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic DivStartE,
  output logic DivBusy,
  output logic DivDone
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    DivBusy = 1'b0;
    DivDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DivStartE) begin
          DivBusy = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        DivBusy = 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        DivDone = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RV32IM hazard controller: EX forwarding, load-use stall, branch flush, divider interlock, stall counter.
// Divider interlock is built only when HAZARD_DIV_INTERLOCK_EN is defined; otherwise its outputs are tied 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int PERF_W     = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hif
);

  localparam logic [REG_AW-1:0] X0 = '0;

  logic              div_busy, div_done;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall_f, stall_d, stall_e;
  logic              flush_d, flush_e, flush_m;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [1:0] fwd_sel(
    input logic              wm, input logic [REG_AW-1:0] rdm,
    input logic              ww, input logic [REG_AW-1:0] rdw,
    input logic [REG_AW-1:0] rs
  );
    if (wm && rdm != X0 && rdm == rs)      return FWD_MEM;
    else if (ww && rdw != X0 && rdw == rs) return FWD_WB;
    else                                   return FWD_NONE;
  endfunction

`ifdef HAZARD_DIV_INTERLOCK_EN
  div_interlock_fsm #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .DivStartE (hif.DivStartE),
    .DivBusy   (div_busy),
    .DivDone   (div_done)
  );
`else
  localparam int unused_div_cycles = DIV_CYCLES;
  logic unused_div_start;
  assign unused_div_start = hif.DivStartE;
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
`endif

  assign load_use = hif.MemReadE && hif.RD_E != X0 &&
                    (hif.RD_E == hif.Rs1_D || hif.RD_E == hif.Rs2_D);

  // Priority: divider stall > branch flush > load-use; everything reads 0 while in reset.
  always_comb begin
    fwd_a   = FWD_NONE;
    fwd_b   = FWD_NONE;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst) begin
      fwd_a = fwd_sel(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.Rs1_E);
      fwd_b = fwd_sel(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.Rs2_E);
      if (div_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hif.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && stall_cnt_q != {PERF_W{1'b1}}) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign hif.ForwardAE  = fwd_a;
  assign hif.ForwardBE  = fwd_b;
  assign hif.StallF     = stall_f;
  assign hif.StallD     = stall_d;
  assign hif.StallE     = stall_e;
  assign hif.FlushD     = flush_d;
  assign hif.FlushE     = flush_e;
  assign hif.FlushM     = flush_m;
  assign hif.DivBusy    = rst & div_busy;
  assign hif.DivDone    = rst & div_done;
  assign hif.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (DIV_CYCLES=4, PERF_W=4): table vectors plus divider, reset and saturation sequences.
module tb_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_DIV_INTERLOCK_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, busy, done;
  } exp_t;

  typedef struct {
    logic       wm;
    logic [4:0] rdm;
    logic       ww;
    logic [4:0] rdw, rs1d, rs2d, rs1e, rs2e, rde;
    logic       mr, pc;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t       o;
    logic [3:0] cnt;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.REG_AW(5), .PERF_W(4)) hif ();

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .PERF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0] exp_cnt = '0;
  sb_t        sbq[$];
  vec_t       tbl[10];

  function automatic exp_t mk(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd, logic se,
                              logic fd, logic fe, logic fm, logic busy, logic done);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se;
    e.fd = fd; e.fe = fe; e.fm = fm; e.busy = busy; e.done = done;
    return e;
  endfunction

  function automatic vec_t mkv(logic wm, logic [4:0] rdm, logic ww, logic [4:0] rdw,
                               logic [4:0] rs1d, logic [4:0] rs2d, logic [4:0] rs1e,
                               logic [4:0] rs2e, logic [4:0] rde, logic mr, logic pc, exp_t e);
    vec_t v;
    v.wm = wm; v.rdm = rdm; v.ww = ww; v.rdw = rdw; v.rs1d = rs1d; v.rs2d = rs2d;
    v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde; v.mr = mr; v.pc = pc; v.e = e;
    return v;
  endfunction

  function automatic exp_t actual();
    return mk(hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
              hif.FlushD, hif.FlushE, hif.FlushM, hif.DivBusy, hif.DivDone);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic set_in(input vec_t v, input logic ds);
    hif.RegWriteM = v.wm;  hif.RD_M = v.rdm;  hif.RegWriteW = v.ww;  hif.RD_W = v.rdw;
    hif.Rs1_D = v.rs1d;    hif.Rs2_D = v.rs2d; hif.Rs1_E = v.rs1e;   hif.Rs2_E = v.rs2e;
    hif.RD_E = v.rde;      hif.MemReadE = v.mr; hif.PCSrcE = v.pc;   hif.DivStartE = ds;
  endtask

  // Inputs are already driven just after a rising edge; result is sampled on the falling edge.
  task automatic step(input string nm, input exp_t e);
    sb_t s;
    s.o = e;
    s.cnt = exp_cnt;
    sbq.push_back(s);
    if (e.sf && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    s = sbq.pop_front();
    check({nm, ".out"}, 16'(actual()), 16'(s.o));
    check({nm, ".cnt"}, 16'(hif.StallCount), 16'(s.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    // Hazard-triggering inputs during reset must still give all-zero outputs.
    set_in(mkv(1, 5'd5, 1, 5'd5, 5'd7, 5'd7, 5'd5, 5'd5, 5'd7, 1, 1, '0), 1'b1);
    #2;
    check("reset.out", 16'(actual()), 16'h0);
    check("reset.cnt", 16'(hif.StallCount), 16'h0);
    set_in(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  vec_t z;
  vec_t lu;

  initial begin
    z  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    lu = mkv(0, 0, 0, 0, 0, 5'd7, 0, 0, 5'd7, 1, 0, '0);

    tbl[0] = mkv(1, 5'd5, 1, 5'd5, 0, 0, 5'd5, 0, 0, 0, 0, mk(FWD_MEM, FWD_NONE, 0,0,0,0,0,0,0,0));
    tbl[1] = mkv(1, 5'd0, 1, 5'd5, 0, 0, 5'd5, 0, 0, 0, 0, mk(FWD_WB,  FWD_NONE, 0,0,0,0,0,0,0,0));
    tbl[2] = mkv(1, 5'd5, 0, 5'd5, 0, 0, 5'd0, 5'd5, 0, 0, 0, mk(FWD_NONE, FWD_MEM, 0,0,0,0,0,0,0,0));
    tbl[3] = mkv(1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, mk(FWD_NONE, FWD_NONE, 0,0,0,0,0,0,0,0));
    tbl[4] = mkv(0, 5'd5, 1, 5'd6, 0, 0, 5'd5, 5'd6, 0, 0, 0, mk(FWD_NONE, FWD_WB, 0,0,0,0,0,0,0,0));
    tbl[5] = mkv(0, 0, 0, 0, 0, 5'd7, 0, 0, 5'd7, 1, 0, mk(FWD_NONE, FWD_NONE, 1,1,0,0,1,0,0,0));
    tbl[6] = mkv(0, 0, 0, 0, 0, 5'd7, 0, 0, 5'd7, 1, 1, mk(FWD_NONE, FWD_NONE, 0,0,0,1,1,0,0,0));
    tbl[7] = mkv(0, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 0, mk(FWD_NONE, FWD_NONE, 0,0,0,0,0,0,0,0));
    tbl[8] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(FWD_NONE, FWD_NONE, 0,0,0,1,1,0,0,0));
    tbl[9] = mkv(1, 5'd3, 1, 5'd3, 5'd7, 0, 5'd3, 5'd3, 5'd7, 0, 0, mk(FWD_MEM, FWD_MEM, 0,0,0,0,0,0,0,0));

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i], 1'b0);
      step($sformatf("vec%0d", i), tbl[i].e);
    end
    set_in(z, 1'b0);
    step("after_vec", mk(0, 0, 0,0,0,0,0,0,0,0));

    // Divide with a taken branch and a load-use hazard arriving while the divider holds EX.
    do_reset();
    set_in(z, 1'b1);
    step("div_c0", mk(0, 0, DIV_EN, DIV_EN, DIV_EN, 0, 0, DIV_EN, DIV_EN, 0));
    hif.PCSrcE = 1'b1;
    step("div_c1_br", mk(0, 0, DIV_EN, DIV_EN, DIV_EN, !DIV_EN, !DIV_EN, DIV_EN, DIV_EN, 0));
    set_in(lu, 1'b1);
    step("div_c2_lu", mk(0, 0, 1, 1, DIV_EN, 0, !DIV_EN, DIV_EN, DIV_EN, 0));
    set_in(z, 1'b1);
    step("div_c3", mk(0, 0, DIV_EN, DIV_EN, DIV_EN, 0, 0, DIV_EN, DIV_EN, 0));
    step("div_c4_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DIV_EN));
    set_in(z, 1'b0);
    step("div_c5_idle", mk(0, 0, 0,0,0,0,0,0,0,0));

    // Reset asserted on cycle 2 of a divide, then a fresh full-length divide.
    do_reset();
    set_in(z, 1'b1);
    step("rdiv_c0", mk(0, 0, DIV_EN, DIV_EN, DIV_EN, 0, 0, DIV_EN, DIV_EN, 0));
    step("rdiv_c1", mk(0, 0, DIV_EN, DIV_EN, DIV_EN, 0, 0, DIV_EN, DIV_EN, 0));
    rst = 1'b0;
    #1;
    check("rdiv_async_busy", 16'(hif.DivBusy), 16'h0);
    check("rdiv_async_cnt", 16'(hif.StallCount), 16'h0);
    set_in(z, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_cnt = '0;
    set_in(z, 1'b1);
    for (int c = 0; c < 4; c++)
      step($sformatf("rdiv2_c%0d", c), mk(0, 0, DIV_EN, DIV_EN, DIV_EN, 0, 0, DIV_EN, DIV_EN, 0));
    step("rdiv2_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DIV_EN));
    set_in(z, 1'b0);
    step("rdiv2_idle", mk(0, 0, 0,0,0,0,0,0,0,0));

    // Twenty consecutive stall cycles saturate the 4-bit counter.
    do_reset();
    set_in(lu, 1'b0);
    for (int c = 0; c < 20; c++)
      step($sformatf("sat_c%0d", c), mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    set_in(z, 1'b0);
    step("sat_end", mk(0, 0, 0,0,0,0,0,0,0,0));
    check("sat_value", 16'(hif.StallCount), 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
